// File: rtl/count_seq_decoder.sv
// count_seq_decoder
// Passive monitor on a 3-bit counter bus. It tracks the previously sampled
// value and classifies each new sample as the operation that most likely
// produced the transition: INC, ROT, SET, CLR or ERR (illegal).
// It also keeps saturating per-operation event counts and a registered
// error flag derived from the error count.
module count_seq_decoder #(
    parameter int CNT_W      = 8,
    parameter int ERR_THRESH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       count_in,
    input  logic             sample_en,
    input  logic             src_reset,
    input  logic             clear,
    output logic             op_valid,
    output logic [2:0]       op,
    output logic [CNT_W-1:0] inc_cnt,
    output logic [CNT_W-1:0] rot_cnt,
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] clr_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag
);

    // Operation codes presented on op
    localparam logic [2:0] OP_INC = 3'd0;
    localparam logic [2:0] OP_ROT = 3'd1;
    localparam logic [2:0] OP_SET = 3'd2;
    localparam logic [2:0] OP_CLR = 3'd3;
    localparam logic [2:0] OP_ERR = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] THRESH   = CNT_W'(ERR_THRESH);

    // EMPTY: no previous sample held; TRACK: prev_r is valid history
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [2:0]       prev_r;
    logic [2:0]       prev_s;
    logic             op_valid_s;
    logic [2:0]       op_s;
    logic [2:0]       decode_s;
    logic [CNT_W-1:0] inc_cnt_s;
    logic [CNT_W-1:0] rot_cnt_s;
    logic [CNT_W-1:0] set_cnt_s;
    logic [CNT_W-1:0] clr_cnt_s;
    logic [CNT_W-1:0] err_cnt_s;
    logic             err_flag_s;

    // Classify a transition p -> n. Order matters: earlier rules win, which
    // resolves the ambiguous cases (e.g. 111->000 is INC, 000->000 is ROT).
    // A source reset forces CLR even when the observed value is nonzero.
    function automatic logic [2:0] classify(
        input logic [2:0] p,
        input logic [2:0] n,
        input logic       src_rst
    );
        logic [2:0] res;
        if (src_rst) begin
            res = OP_CLR;
        end else if (n == (p + 3'd1)) begin
            res = OP_INC;
        end else if (n == {p[1:0], p[2]}) begin
            res = OP_ROT;
        end else if (n == 3'b111) begin
            res = OP_SET;
        end else if (n == 3'b000) begin
            res = OP_CLR;
        end else begin
            res = OP_ERR;
        end
        return res;
    endfunction

    // Saturating increment: counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        if (v == CNT_MAX) begin
            res = v;
        end else begin
            res = v + CNT_ONE;
        end
        return res;
    endfunction

    // Decode of the current sample against the held history
    assign decode_s = classify(prev_r, count_in, src_reset);

    // Next-state, history, decode and counter update logic
    always_comb begin
        state_s    = state_r;
        prev_s     = prev_r;
        op_valid_s = 1'b0;
        op_s       = op;
        inc_cnt_s  = inc_cnt;
        rot_cnt_s  = rot_cnt;
        set_cnt_s  = set_cnt;
        clr_cnt_s  = clr_cnt;
        err_cnt_s  = err_cnt;

        if (clear) begin
            // Clear beats sampling: drop history and all statistics
            state_s   = ST_EMPTY;
            prev_s    = 3'b000;
            inc_cnt_s = CNT_ZERO;
            rot_cnt_s = CNT_ZERO;
            set_cnt_s = CNT_ZERO;
            clr_cnt_s = CNT_ZERO;
            err_cnt_s = CNT_ZERO;
        end else if (sample_en) begin
            case (state_r)
                ST_EMPTY: begin
                    // First sample only seeds history, even under src_reset
                    prev_s  = count_in;
                    state_s = ST_TRACK;
                end
                ST_TRACK: begin
                    op_s       = decode_s;
                    op_valid_s = 1'b1;
                    prev_s     = count_in;
                    case (decode_s)
                        OP_INC:  inc_cnt_s = sat_inc(inc_cnt);
                        OP_ROT:  rot_cnt_s = sat_inc(rot_cnt);
                        OP_SET:  set_cnt_s = sat_inc(set_cnt);
                        OP_CLR:  clr_cnt_s = sat_inc(clr_cnt);
                        OP_ERR:  err_cnt_s = sat_inc(err_cnt);
                        default: err_cnt_s = sat_inc(err_cnt);
                    endcase
                end
                default: begin
                    state_s = ST_EMPTY;
                    prev_s  = 3'b000;
                end
            endcase
        end else begin
            // Idle cycle: history, op and counters hold
            state_s = state_r;
        end

        // Flag follows the post-update count so it rises with err_cnt
        err_flag_s = (err_cnt_s >= THRESH);
    end

    // State, history and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_EMPTY;
            prev_r   <= 3'b000;
            op_valid <= 1'b0;
            op       <= 3'b000;
            inc_cnt  <= CNT_ZERO;
            rot_cnt  <= CNT_ZERO;
            set_cnt  <= CNT_ZERO;
            clr_cnt  <= CNT_ZERO;
            err_cnt  <= CNT_ZERO;
            err_flag <= 1'b0;
        end else begin
            state_r  <= state_s;
            prev_r   <= prev_s;
            op_valid <= op_valid_s;
            op       <= op_s;
            inc_cnt  <= inc_cnt_s;
            rot_cnt  <= rot_cnt_s;
            set_cnt  <= set_cnt_s;
            clr_cnt  <= clr_cnt_s;
            err_cnt  <= err_cnt_s;
            err_flag <= err_flag_s;
        end
    end

endmodule

// File: tb/tb_count_seq_decoder.sv
// Directed testbench for count_seq_decoder. A small reference model
// predicts each decode; expected ops go into a queue when a sample is
// driven and are popped when the DUT presents op_valid. A second instance
// with narrow counters and a higher error threshold covers saturation and
// the threshold boundary.
module tb_count_seq_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] count_in;
    logic       sample_en;
    logic       src_reset;
    logic       clear;

    logic       op_valid;
    logic [2:0] op;
    logic [7:0] inc_cnt, rot_cnt, set_cnt, clr_cnt, err_cnt;
    logic       err_flag;

    logic       s_op_valid;
    logic [2:0] s_op;
    logic [1:0] s_inc_cnt, s_rot_cnt, s_set_cnt, s_clr_cnt, s_err_cnt;
    logic       s_err_flag;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];
    bit         m_have;
    logic [2:0] m_prev;

    always #5 clk = ~clk;

    count_seq_decoder #(.CNT_W(8), .ERR_THRESH(1)) dut (
        .clk(clk), .reset(reset), .count_in(count_in), .sample_en(sample_en),
        .src_reset(src_reset), .clear(clear), .op_valid(op_valid), .op(op),
        .inc_cnt(inc_cnt), .rot_cnt(rot_cnt), .set_cnt(set_cnt),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt), .err_flag(err_flag)
    );

    count_seq_decoder #(.CNT_W(2), .ERR_THRESH(2)) dut_small (
        .clk(clk), .reset(reset), .count_in(count_in), .sample_en(sample_en),
        .src_reset(src_reset), .clear(clear), .op_valid(s_op_valid), .op(s_op),
        .inc_cnt(s_inc_cnt), .rot_cnt(s_rot_cnt), .set_cnt(s_set_cnt),
        .clr_cnt(s_clr_cnt), .err_cnt(s_err_cnt), .err_flag(s_err_flag)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode, first matching rule wins
    function automatic logic [2:0] model_op(input logic [2:0] p, input logic [2:0] n,
                                            input logic sr);
        logic [2:0] nxt;
        logic [2:0] rot;
        nxt = p + 3'd1;
        rot = {p[1], p[0], p[2]};
        if (sr)               return 3'd3;
        if (n == nxt)         return 3'd0;
        if (n == rot)         return 3'd1;
        if (n == 3'b111)      return 3'd2;
        if (n == 3'b000)      return 3'd3;
        return 3'd4;
    endfunction

    // One clock of stimulus, then check op_valid/op one edge later
    task automatic smp(input logic en, input logic [2:0] v, input logic sr);
        logic       exp_valid;
        logic [2:0] e;
        sample_en = en;
        count_in  = v;
        src_reset = sr;
        clear     = 1'b0;
        exp_valid = 1'b0;
        if (en) begin
            if (m_have) begin
                exp_q.push_back(model_op(m_prev, v, sr));
                exp_valid = 1'b1;
            end
            m_have = 1'b1;
            m_prev = v;
        end
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        src_reset = 1'b0;
        chk("op_valid", 16'(op_valid), 16'(exp_valid));
        chk("s_op_valid", 16'(s_op_valid), 16'(exp_valid));
        if (exp_valid) begin
            e = exp_q.pop_front();
            chk("op", 16'(op), 16'(e));
        end
    endtask

    task automatic do_clear();
        clear     = 1'b1;
        sample_en = 1'b1;
        count_in  = 3'b001;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        sample_en = 1'b0;
        m_have    = 1'b0;
        chk("clr_op_valid", 16'(op_valid), 16'd0);
        chk("clr_cnts", 16'(inc_cnt | rot_cnt | set_cnt | clr_cnt | err_cnt), 16'd0);
        chk("clr_err_flag", 16'(err_flag), 16'd0);
    endtask

    task automatic chk_cnts(input string tag, input int i, input int r, input int s,
                            input int c, input int e);
        chk({tag, "_inc"}, 16'(inc_cnt), 16'(i));
        chk({tag, "_rot"}, 16'(rot_cnt), 16'(r));
        chk({tag, "_set"}, 16'(set_cnt), 16'(s));
        chk({tag, "_clr"}, 16'(clr_cnt), 16'(c));
        chk({tag, "_err"}, 16'(err_cnt), 16'(e));
    endtask

    initial begin
        reset     = 1'b1;
        count_in  = 3'b000;
        sample_en = 1'b0;
        src_reset = 1'b0;
        clear     = 1'b0;
        m_have    = 1'b0;
        m_prev    = 3'b000;
        @(posedge clk);
        #1;
        chk("rst_op_valid", 16'(op_valid), 16'd0);
        chk("rst_op", 16'(op), 16'd0);
        chk("rst_err_flag", 16'(err_flag), 16'd0);
        chk_cnts("rst", 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Three increments
        smp(1'b1, 3'b000, 1'b0);
        smp(1'b1, 3'b001, 1'b0);
        smp(1'b1, 3'b010, 1'b0);
        smp(1'b1, 3'b011, 1'b0);
        chk_cnts("inc3", 3, 0, 0, 0, 0);

        // Three rotates
        do_clear();
        smp(1'b1, 3'b011, 1'b0);
        smp(1'b1, 3'b110, 1'b0);
        smp(1'b1, 3'b101, 1'b0);
        smp(1'b1, 3'b011, 1'b0);
        chk_cnts("rot3", 0, 3, 0, 0, 0);

        // SET, then 111->000 as INC, then 000->000 as ROT; op holds when idle
        do_clear();
        smp(1'b1, 3'b010, 1'b0);
        smp(1'b1, 3'b111, 1'b0);
        smp(1'b1, 3'b000, 1'b0);
        smp(1'b1, 3'b000, 1'b0);
        chk_cnts("mix", 1, 1, 1, 0, 0);
        smp(1'b0, 3'b101, 1'b0);
        chk("op_hold", 16'(op), 16'd1);

        // Forced CLR, then illegal transitions and threshold boundary
        do_clear();
        smp(1'b1, 3'b101, 1'b0);
        smp(1'b1, 3'b000, 1'b1);
        smp(1'b1, 3'b010, 1'b0);
        chk("err_flag_1", 16'(err_flag), 16'd1);
        chk("s_err_flag_1", 16'(s_err_flag), 16'd0);
        smp(1'b1, 3'b010, 1'b0);
        chk("s_err_flag_2", 16'(s_err_flag), 16'd1);
        smp(1'b1, 3'b110, 1'b1);
        chk_cnts("err", 0, 0, 0, 2, 2);

        // Five increments: narrow counter saturates at 3
        do_clear();
        for (int k = 0; k < 6; k++) begin
            smp(1'b1, 3'(k), 1'b0);
        end
        chk("inc5", 16'(inc_cnt), 16'd5);
        chk("s_inc_sat", 16'(s_inc_cnt), 16'd3);
        do_clear();
        chk("s_inc_clr", 16'(s_inc_cnt), 16'd0);
        // src_reset in EMPTY only seeds history; then 110->111 is INC
        smp(1'b1, 3'b110, 1'b1);
        smp(1'b1, 3'b111, 1'b0);
        chk_cnts("empty_sr", 1, 0, 0, 0, 0);

        // Gap in sample_en: 100, idle, 101 -> single INC
        do_clear();
        smp(1'b1, 3'b100, 1'b0);
        smp(1'b0, 3'b010, 1'b0);
        smp(1'b1, 3'b101, 1'b0);
        chk_cnts("gap", 1, 0, 0, 0, 0);

        // Async reset mid-cycle clears outputs before the next edge
        #2;
        reset = 1'b1;
        #1;
        chk("areset_op_valid", 16'(op_valid), 16'd0);
        chk("areset_op", 16'(op), 16'd0);
        chk("areset_flag", 16'(err_flag), 16'd0);
        chk_cnts("areset", 0, 0, 0, 0, 0);
        reset  = 1'b0;
        m_have = 1'b0;
        smp(1'b1, 3'b001, 1'b0);
        smp(1'b1, 3'b010, 1'b0);
        chk("post_reset_inc", 16'(inc_cnt), 16'd1);
        chk("q_empty", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
